// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Reads are combinational; writes, busy set and busy clear happen on the rising edge.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RegWrite,
    input  logic [AW-1:0]          WriteReg,
    input  logic [WIDTH-1:0]       WriteD,
    input  logic [NREAD*AW-1:0]    ReadReg,
    output logic [NREAD*WIDTH-1:0] ReadData,
    input  logic                   BusySet,
    input  logic [AW-1:0]          BusyReg,
    output logic [NREAD-1:0]       ReadBusy,
    output logic                   AnyBusy
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             set_ok;
    logic [AW-1:0]    ra;
    logic             hit;

    // An index is usable when it is in range and is not the hardwired zero register.
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return ({1'b0, idx} < DEPTH_W) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    assign wr_ok  = RegWrite && idx_ok(WriteReg);
    assign set_ok = BusySet  && idx_ok(BusyReg);

    // Set is applied after clear: a newly issued producer outranks the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)
            busy_d[WriteReg] = 1'b0;
        if (set_ok)
            busy_d[BusyReg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < DEPTH; r++)
                mem_q[r] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wr_ok)
                mem_q[WriteReg] <= WriteD;
        end
    end

    // A forwarded write also hides the busy bit it is about to clear.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        ra       = '0;
        hit      = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = ReadReg[i*AW +: AW];
            hit = (BYPASS != 0) && wr_ok && (WriteReg == ra);
            if (rst_n && idx_ok(ra)) begin
                ReadData[i*WIDTH +: WIDTH] = hit ? WriteD : mem_q[ra];
                ReadBusy[i]                = busy_q[ra] && !hit;
            end
        end
    end

    assign AnyBusy = |ReadBusy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (zero reg + bypass) and a 16x24, 4-port
// instance without zero reg or bypass, checked against an array model every cycle.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=32 DEPTH=32 NREAD=2 ZERO_REG=1 BYPASS=1
    logic        weA, bsA;
    logic [4:0]  wrA, brA;
    logic [31:0] wdA;
    logic [9:0]  rrA;
    logic [63:0] rdA;
    logic [1:0]  rbA;
    logic        anyA;

    // Instance B: WIDTH=16 DEPTH=24 NREAD=4 ZERO_REG=0 BYPASS=0
    logic        weB, bsB;
    logic [4:0]  wrB, brB;
    logic [15:0] wdB;
    logic [19:0] rrB;
    logic [63:0] rdB;
    logic [3:0]  rbB;
    logic        anyB;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .RegWrite(weA), .WriteReg(wrA), .WriteD(wdA),
        .ReadReg(rrA), .ReadData(rdA), .BusySet(bsA), .BusyReg(brA),
        .ReadBusy(rbA), .AnyBusy(anyA)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(24), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .RegWrite(weB), .WriteReg(wrB), .WriteD(wdB),
        .ReadReg(rrB), .ReadData(rdB), .BusySet(bsB), .BusyReg(brB),
        .ReadBusy(rbB), .AnyBusy(anyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mA [32];
    logic        bA [32];
    logic [15:0] mB [24];
    logic        bB [24];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin mA[r] <= '0; bA[r] <= 1'b0; end
            for (int r = 0; r < 24; r++) begin mB[r] <= '0; bB[r] <= 1'b0; end
        end else begin
            if (weA && wrA != 0) begin mA[wrA] <= wdA; bA[wrA] <= 1'b0; end
            if (bsA && brA != 0) bA[brA] <= 1'b1;
            if (weB && wrB < 24) begin mB[wrB] <= wdB; bB[wrB] <= 1'b0; end
            if (bsB && brB < 24) bB[brB] <= 1'b1;
        end
    end

    function automatic logic [31:0] expA_rd(input int p);
        int idx = int'(rrA[p*5 +: 5]);
        if (!rst_n || idx == 0) return 32'h0;
        if (weA && int'(wrA) == idx) return wdA;
        return mA[idx];
    endfunction

    function automatic logic expA_busy(input int p);
        int idx = int'(rrA[p*5 +: 5]);
        if (!rst_n || idx == 0) return 1'b0;
        if (weA && int'(wrA) == idx) return 1'b0;
        return bA[idx];
    endfunction

    function automatic logic [15:0] expB_rd(input int p);
        int idx = int'(rrB[p*5 +: 5]);
        if (!rst_n || idx >= 24) return 16'h0;
        return mB[idx];
    endfunction

    function automatic logic expB_busy(input int p);
        int idx = int'(rrB[p*5 +: 5]);
        if (!rst_n || idx >= 24) return 1'b0;
        return bB[idx];
    endfunction

    logic [1:0] ebA;
    logic [3:0] ebB;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("A_rd%0d", p), rdA[p*32 +: 32], expA_rd(p));
            ebA[p] = expA_busy(p);
        end
        chk("A_busy", rbA, ebA);
        chk("A_any", anyA, |ebA);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("B_rd%0d", p), rdB[p*16 +: 16], expB_rd(p));
            ebB[p] = expB_busy(p);
        end
        chk("B_busy", rbB, ebB);
        chk("B_any", anyB, |ebB);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int r);
        logic [15:0] v;
        v = 16'h3C00 + 16'(r) * 16'h0101;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        weA = 0; bsA = 0; wrA = 0; brA = 0; wdA = 0; rrA = 0;
        weB = 0; bsB = 0; wrB = 0; brB = 0; wdB = 0; rrB = 0;
        #1;
        chk("reset_rdA", rdA, 64'h0);
        chk("reset_busyA", rbA, 2'b00);
        chk("reset_rdB", rdB, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // write r5, forwarded in the same cycle, stored after the edge
        weA = 1; wrA = 5; wdA = 32'hDEADBEEF; rrA = {5'd5, 5'd5};
        #1 chk("bypass_r5", rdA[31:0], 32'hDEADBEEF);
        tick();
        weA = 0;
        #1 chk("stored_r5_p0", rdA[31:0], 32'hDEADBEEF);
        chk("stored_r5_p1", rdA[63:32], 32'hDEADBEEF);

        // asynchronous clear between edges
        tick();
        #1 rst_n = 1'b0;
        #1 chk("async_clr_r5", rdA[31:0], 32'h0);
        chk("async_clr_busy", rbA, 2'b00);
        #4 rst_n = 1'b1;
        tick();
        chk("after_rel_r5", rdA[31:0], 32'h0);

        // hardwired zero register
        weA = 1; wrA = 0; wdA = 32'h12345678; rrA = {5'd0, 5'd0};
        #1 chk("zero_wr_same", rdA, 64'h0);
        tick();
        weA = 0;
        #1 chk("zero_wr_after", rdA, 64'h0);
        bsA = 1; brA = 0;
        tick();
        bsA = 0;
        #1 chk("zero_busy", rbA, 2'b00);

        // bypass of a new value over an old one on both ports
        weA = 1; wrA = 7; wdA = 32'h11111111; rrA = {5'd7, 5'd7};
        tick();
        wdA = 32'hA5A5A5A5;
        #1 chk("bypass_r7", rdA, {32'hA5A5A5A5, 32'hA5A5A5A5});
        tick();
        weA = 0;
        #1 chk("stored_r7", rdA, {32'hA5A5A5A5, 32'hA5A5A5A5});

        // scoreboard: set, hold, clear by write, set-wins, set/clear different regs
        rrA = {5'd3, 5'd3}; bsA = 1; brA = 3;
        #1 chk("busy_before_set", rbA, 2'b00);
        tick();
        bsA = 0;
        #1 chk("busy_set", rbA, 2'b11);
        chk("any_set", anyA, 1'b1);
        tick(); tick(); tick();
        chk("busy_held", rbA, 2'b11);
        weA = 1; wrA = 3; wdA = 32'h33;
        #1 chk("busy_masked_bypass", rbA, 2'b00);
        chk("any_masked_bypass", anyA, 1'b0);
        tick();
        weA = 0;
        #1 chk("busy_cleared", rbA, 2'b00);
        bsA = 1; brA = 3; weA = 1; wrA = 3; wdA = 32'h34;
        tick();
        bsA = 0; weA = 0;
        #1 chk("set_wins", rbA, 2'b11);
        rrA = {5'd3, 5'd4}; bsA = 1; brA = 4; weA = 1; wrA = 3; wdA = 32'h35;
        tick();
        bsA = 0; weA = 0;
        #1 chk("set_clr_diff", rbA, 2'b01);

        // instance B: no zero register, no bypass
        weB = 1; wrB = 0; wdB = 16'h5678; rrB = '0;
        #1 chk("B_nobypass_old", rdB[15:0], 16'h0000);
        tick();
        weB = 0;
        #1 chk("B_r0_new_p0", rdB[15:0], 16'h5678);
        chk("B_r0_new_p3", rdB[63:48], 16'h5678);

        for (int r = 0; r < 24; r++) begin
            weB = 1; wrB = 5'(r); wdB = pat(r);
            tick();
        end
        weB = 0;
        for (int base = 0; base < 24; base += 4) begin
            for (int p = 0; p < 4; p++)
                rrB[p*5 +: 5] = 5'(base + ((p + base / 4) % 4));
            #1;
            for (int p = 0; p < 4; p++)
                chk($sformatf("B_sweep_r%0d", base + ((p + base / 4) % 4)),
                    rdB[p*16 +: 16], pat(base + ((p + base / 4) % 4)));
            tick();
        end

        // out-of-range write is dropped and does not alias
        weB = 1; wrB = 30; wdB = 16'hFFFF; rrB = {5'd30, 5'd6, 5'd14, 5'd30};
        #1 chk("B_oor_same", rdB[15:0], 16'h0000);
        tick();
        weB = 0;
        #1 chk("B_oor_p0", rdB[15:0], 16'h0000);
        chk("B_alias_r14", rdB[31:16], pat(14));
        chk("B_alias_r6", rdB[47:32], pat(6));
        chk("B_oor_p3", rdB[63:48], 16'h0000);

        // B scoreboard: out-of-range set ignored, no bypass masking
        bsB = 1; brB = 30;
        tick();
        bsB = 0;
        #1 chk("B_busy_oor", rbB, 4'b0000);
        bsB = 1; brB = 10; rrB = {5'd30, 5'd10, 5'd11, 5'd10};
        tick();
        bsB = 0;
        #1 chk("B_busy_set", rbB, 4'b0101);
        chk("B_any_set", anyB, 1'b1);
        weB = 1; wrB = 10; wdB = 16'h0A0A;
        #1 chk("B_busy_during_wr", rbB, 4'b0101);
        tick();
        weB = 0;
        #1 chk("B_busy_cleared", rbB, 4'b0000);
        chk("B_r10_data", rdB[15:0], 16'h0A0A);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
